// File: rtl/cfg_pkg.sv
// Shared constants, FSM encoding and checksum helper for the config readback path.
// The packet is header, data bytes in address order, then an XOR checksum.
package cfg_pkg;

   localparam int          CFG_N_BYTES = 113;
   localparam logic [7:0]  CFG_HDR     = 8'hA5;
   // 50 MHz / 115200 baud
   localparam int          CFG_CLK_DIV = 434;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HDR   = 3'd1,
      ST_FETCH = 3'd2,
      ST_WAIT  = 3'd3,
      ST_SEND  = 3'd4,
      ST_CSUM  = 3'd5,
      ST_FIN   = 3'd6
   } cfg_state_e;

   function automatic logic [7:0] cfg_csum_step(input logic [7:0] acc, input logic [7:0] data);
      return acc ^ data;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first, idle high. A launch while idle drives the start
// bit on the next edge; tx_busy drops on the cycle after the stop bit ends.
module uart_tx_byte
   import cfg_pkg::*;
#(
   parameter int CLK_DIV = CFG_CLK_DIV
) (
   input  logic       clk_TX,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy
);

   localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

   logic          tx_q, tx_d;
   logic          active_q, active_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;

   // Frame sequencing: bit index 0 is the start bit, 1..8 data, 9 the stop bit.
   always_comb begin
      tx_d     = tx_q;
      active_d = active_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      if (!active_q) begin
         if (tx_start) begin
            active_d = 1'b1;
            tx_d     = 1'b0;
            baud_d   = {BW{1'b0}};
            bit_d    = 4'd0;
            shift_d  = tx_data;
         end else begin
            tx_d     = 1'b1;
         end
      end else if (baud_q == BAUD_LAST) begin
         baud_d = {BW{1'b0}};
         if (bit_q == 4'd9) begin
            active_d = 1'b0;
            tx_d     = 1'b1;
         end else if (bit_q == 4'd8) begin
            bit_d    = bit_q + 4'd1;
            tx_d     = 1'b1;
         end else begin
            bit_d    = bit_q + 4'd1;
            tx_d     = shift_q[0];
            shift_d  = {1'b0, shift_q[7:1]};
         end
      end else begin
         baud_d = baud_q + BW'(1);
      end
   end

   // State register; reset parks the line high.
   always_ff @(posedge clk_TX) begin
      if (rst) begin
         tx_q     <= 1'b1;
         active_q <= 1'b0;
         baud_q   <= {BW{1'b0}};
         bit_q    <= 4'd0;
         shift_q  <= 8'h00;
      end else begin
         tx_q     <= tx_d;
         active_q <= active_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
      end
   end

   assign tx      = tx_q;
   assign tx_busy = active_q;

endmodule

// File: rtl/cfg_readback_tx.sv
// Dumps the configuration store over UART as one packet: header, N_BYTES data
// bytes read through a 1-cycle synchronous RAM port, then their XOR checksum.
module cfg_readback_tx
   import cfg_pkg::*;
#(
   parameter int         N_BYTES  = CFG_N_BYTES,
   parameter int         CLK_DIV  = CFG_CLK_DIV,
   parameter logic [7:0] HDR_BYTE = CFG_HDR
) (
   input  logic       clk_TX,
   input  logic       rst,
   input  logic       start,
   output logic [7:0] r_addr,
   input  logic [7:0] r_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [7:0] LAST_ADDR = 8'(N_BYTES - 1);

   cfg_state_e state_q, state_d;
   logic [7:0] r_addr_q, r_addr_d;
   logic [7:0] checksum_q, checksum_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       launched_q, launched_d;

   logic       tx_start_s;
   logic [7:0] tx_data_s;
   logic       tx_busy_s;

   // WAIT hands r_data straight to the serializer (its shift register is the byte
   // register), which keeps the gap between data frames at three idle cycles.
   always_comb begin
      state_d    = state_q;
      r_addr_d   = r_addr_q;
      checksum_d = checksum_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      launched_d = launched_q;
      tx_start_s = 1'b0;
      tx_data_s  = 8'h00;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d    = ST_HDR;
               busy_d     = 1'b1;
               r_addr_d   = 8'h00;
               checksum_d = 8'h00;
               launched_d = 1'b0;
            end else begin
               busy_d     = 1'b0;
            end
         end
         ST_HDR: begin
            tx_data_s = HDR_BYTE;
            if (!launched_q) begin
               tx_start_s = 1'b1;
               launched_d = 1'b1;
            end else if (!tx_busy_s) begin
               state_d    = ST_FETCH;
               launched_d = 1'b0;
            end else begin
               launched_d = 1'b1;
            end
         end
         ST_FETCH: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            tx_start_s = 1'b1;
            tx_data_s  = r_data;
            checksum_d = cfg_csum_step(checksum_q, r_data);
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            if (tx_busy_s) begin
               state_d = ST_SEND;
            end else if (r_addr_q == LAST_ADDR) begin
               state_d    = ST_CSUM;
               launched_d = 1'b0;
            end else begin
               r_addr_d = r_addr_q + 8'd1;
               state_d  = ST_FETCH;
            end
         end
         ST_CSUM: begin
            tx_data_s = checksum_q;
            if (!launched_q) begin
               tx_start_s = 1'b1;
               launched_d = 1'b1;
            end else if (!tx_busy_s) begin
               state_d    = ST_FIN;
               launched_d = 1'b0;
            end else begin
               launched_d = 1'b1;
            end
         end
         ST_FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            launched_d = 1'b0;
         end
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge clk_TX) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         r_addr_q   <= 8'h00;
         checksum_q <= 8'h00;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         launched_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         r_addr_q   <= r_addr_d;
         checksum_q <= checksum_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         launched_q <= launched_d;
      end
   end

   uart_tx_byte #(
      .CLK_DIV (CLK_DIV)
   ) u_ser (
      .clk_TX   (clk_TX),
      .rst      (rst),
      .tx_start (tx_start_s),
      .tx_data  (tx_data_s),
      .tx       (tx),
      .tx_busy  (tx_busy_s)
   );

   assign r_addr = r_addr_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_cfg_readback_tx.sv
// Scoreboard bench: packets are predicted from the RAM image when a dump is
// requested; a line monitor samples tx every cycle and compares whole frames.
module tb_cfg_readback_tx;

   localparam int N     = 113;
   localparam int DIV   = 4;
   localparam int PKT   = N + 2;
   localparam int FRAME = 10 * DIV;

   logic       clk_TX = 1'b0;
   logic       rst    = 1'b1;
   logic       start  = 1'b0;
   logic [7:0] r_addr;
   logic [7:0] r_data;
   logic       tx, busy, done;

   logic [7:0] mem [0:255];
   logic [7:0] exp_q [$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [FRAME-1:0] smp;
   int  rx_cnt = 0;
   bit  rx_on  = 1'b0;
   int  gap    = 0;
   int  pkt_idx = 0;
   int  frames_started = 0;
   int  done_cnt = 0;
   int  since_done = 0;
   bit  done_armed = 1'b0;
   bit  hold_mode  = 1'b0;

   cfg_readback_tx #(
      .N_BYTES  (N),
      .CLK_DIV  (DIV),
      .HDR_BYTE (8'hA5)
   ) dut (
      .clk_TX (clk_TX),
      .rst    (rst),
      .start  (start),
      .r_addr (r_addr),
      .r_data (r_data),
      .tx     (tx),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk_TX = ~clk_TX;

   // 1-cycle latency RAM read port
   always @(posedge clk_TX) r_data <= mem[r_addr];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Reference model: header, bytes in address order, XOR of data bytes.
   function automatic void push_packet();
      logic [7:0] c;
      c = 8'h00;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < N; i++) begin
         exp_q.push_back(mem[i]);
         c = c ^ mem[i];
      end
      exp_q.push_back(c);
   endfunction

   function automatic logic [FRAME-1:0] wave_of(input logic [7:0] b);
      logic [FRAME-1:0] w;
      for (int j = 0; j < FRAME; j++) begin
         int k;
         k = j / DIV;
         if (k == 0)      w[j] = 1'b0;
         else if (k == 9) w[j] = 1'b1;
         else             w[j] = b[k-1];
      end
      return w;
   endfunction

   // Line monitor / scoreboard consumer
   always @(negedge clk_TX) begin
      if (rst) begin
         rx_on = 1'b0; rx_cnt = 0; pkt_idx = 0; gap = 0; done_armed = 1'b0;
      end else begin
         if (done) begin
            done_cnt++; pkt_idx = 0; since_done = 0; done_armed = hold_mode;
         end else if (done_armed) begin
            since_done++;
         end
         if (!hold_mode) done_armed = 1'b0;
         if (rx_on) begin
            smp[rx_cnt] = tx;
            rx_cnt++;
            if (rx_cnt == FRAME) begin
               logic [7:0] e;
               rx_on = 1'b0; gap = 0;
               if (exp_q.size() == 0) begin
                  n_checks++; n_fail++;
                  $display("FAIL frame: unexpected frame, samples %h", smp);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame", smp, wave_of(e));
               end
               pkt_idx++;
            end
         end else if (tx == 1'b0) begin
            frames_started++;
            chk("busy_at_frame", busy, 1'b1);
            if (pkt_idx > 0) chk("gap_le3", gap <= 3, 1'b1);
            if (done_armed) chk("done_to_start_le3", since_done <= 3, 1'b1);
            done_armed = 1'b0;
            rx_on = 1'b1; smp[0] = 1'b0; rx_cnt = 1;
         end else begin
            gap++;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk_TX); #1 start = 1'b1;
      @(posedge clk_TX); #1 start = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (frames_started < target && k < budget) begin
         @(negedge clk_TX); #1;
         k++;
      end
      chk(name, frames_started >= target, 1'b1);
   endtask

   task automatic wait_done(input int budget, input string name);
      int k;
      bit seen;
      k = 0; seen = 1'b0;
      while (!seen && k < budget) begin
         @(negedge clk_TX);
         k++;
         if (done) seen = 1'b1;
      end
      chk(name, seen, 1'b1);
   endtask

   task automatic end_checks(input string tag, input int f0, input int d0, input int npk);
      repeat (20) @(negedge clk_TX);
      chk({tag, "_frames"}, frames_started - f0, npk * PKT);
      chk({tag, "_done_pulses"}, done_cnt - d0, npk);
      chk({tag, "_queue_empty"}, exp_q.size(), 0);
      chk({tag, "_busy_low"}, busy, 1'b0);
      chk({tag, "_r_addr_hold"}, r_addr, 8'(N - 1));
   endtask

   task automatic fill_random();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      int f0, d0, seen, k;
      fill_random();
      repeat (5) @(posedge clk_TX);
      #1 rst = 1'b0;

      // 1: idle after reset, then a reset pulse while idle
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_TX);
         chk("idle_state", {tx, busy, done, r_addr}, {1'b1, 1'b0, 1'b0, 8'h00});
      end
      @(posedge clk_TX); #1 rst = 1'b1;
      @(posedge clk_TX); #1 rst = 1'b0;
      @(negedge clk_TX);
      chk("idle_after_rst", {tx, busy, done, r_addr}, {1'b1, 1'b0, 1'b0, 8'h00});

      // 2: ramp pattern, header launch latency
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      f0 = frames_started; d0 = done_cnt;
      @(posedge clk_TX); #1 start = 1'b1;
      push_packet();
      @(posedge clk_TX); #1 start = 1'b0;
      @(negedge clk_TX);
      chk("hdr_before_launch", {busy, tx, r_addr}, {1'b1, 1'b1, 8'h00});
      @(negedge clk_TX);
      chk("hdr_start_bit", tx, 1'b0);
      wait_done(8000, "t2_done_seen");
      end_checks("t2", f0, d0, 1);

      // 3: all 0xFF
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      f0 = frames_started; d0 = done_cnt;
      push_packet();
      pulse_start();
      wait_done(8000, "t3_done_seen");
      end_checks("t3", f0, d0, 1);

      // 4: start pulses while busy are ignored
      fill_random();
      f0 = frames_started; d0 = done_cnt;
      push_packet();
      pulse_start();
      wait_frames(f0 + 12, 2000, "t4_reach_byte10");
      pulse_start();
      wait_frames(f0 + PKT, 8000, "t4_reach_csum");
      pulse_start();
      wait_done(2000, "t4_done_seen");
      end_checks("t4", f0, d0, 1);

      // 5: reset inside data byte 50, then a clean packet
      fill_random();
      push_packet();
      pulse_start();
      wait_frames(frames_started + 52, 4000, "t5_reach_byte50");
      repeat (8) @(posedge clk_TX);
      #1 rst = 1'b1;
      exp_q.delete();
      d0 = done_cnt;
      @(posedge clk_TX); #1 rst = 1'b0;
      @(negedge clk_TX);
      chk("t5_after_rst", {tx, busy, done}, {1'b1, 1'b0, 1'b0});
      repeat (200) @(negedge clk_TX);
      chk("t5_no_done", done_cnt - d0, 0);
      chk("t5_idle_line", {tx, busy}, {1'b1, 1'b0});
      f0 = frames_started; d0 = done_cnt;
      push_packet();
      pulse_start();
      wait_done(8000, "t5_done_seen");
      end_checks("t5", f0, d0, 1);

      // 6: start held high for three back-to-back dumps
      fill_random();
      f0 = frames_started; d0 = done_cnt;
      hold_mode = 1'b1;
      push_packet(); push_packet(); push_packet();
      @(posedge clk_TX); #1 start = 1'b1;
      seen = 0; k = 0;
      while (seen < 3 && k < 20000) begin
         @(negedge clk_TX);
         k++;
         if (done) begin
            seen++;
            if (seen == 3) start = 1'b0;
         end
      end
      start = 1'b0;
      chk("t6_three_dones", seen, 3);
      end_checks("t6", f0, d0, 3);
      hold_mode = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
